dcache_ctrl: RTL and testbench

- Write-back, write-allocate controller for the L1 data cache array. It sits between the CPU memory stage, the data SRAM array and the main-memory port.
- It turns CPU load/store requests into array read, write and fill strobes.
- It stalls the pipeline on a miss, writes back a dirty victim, refills the block from memory, then replays the access.

---
 rtl/dcache_ctrl_if.sv | 67 ++++++
 rtl/dcache_ctrl.sv | 151 +++++++++++++++
 tb/tb_dcache_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_ctrl_if.sv
// ---------------------------------------------------------------------------
// dcache_ctrl_if
//   Bundle of the three buses around the L1 data-cache controller:
//     cpu_*  : load/store request from the memory stage, load data and stall back
//     sram_* : lookup/write/fill strobes to the data array and its lookup result
//     mem_*  : block read/write requests to main memory and the completion pulse
//   Modports:
//     slave  : the controller (dcache_ctrl)
//     master : the surroundings (CPU, array and memory models)
// ---------------------------------------------------------------------------
interface dcache_ctrl_if #(
  parameter int ADDR_W      = 32,
  parameter int BLOCK_BYTES = 16,
  parameter int SETS        = 64
);
  localparam int OFF_W = $clog2(BLOCK_BYTES);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam int BLK_W = 8 * BLOCK_BYTES;

  // CPU side
  logic                     cpu_ren;
  logic                     cpu_wen;
  logic [ADDR_W-1:0]        cpu_addr;
  logic [31:0]              cpu_wdata;
  logic [3:0]               cpu_be;
  logic [31:0]              cpu_rdata;
  logic                     cpu_stall;

  // Data array side
  logic                     sram_ren;
  logic                     sram_wen;
  logic                     sram_memWen;
  logic [BLOCK_BYTES-1:0]   sram_bytesAccess;
  logic [TAG_W+IDX_W-1:0]   sram_blockAddr;
  logic [BLK_W-1:0]         sram_dataIn;
  logic                     sram_hit;
  logic                     sram_dirtyBit;
  logic [TAG_W-1:0]         sram_victimTag;
  logic [BLK_W-1:0]         sram_dataOut;

  // Main memory side
  logic                     mem_ren;
  logic                     mem_wen;
  logic [ADDR_W-1:0]        mem_addr;
  logic [BLK_W-1:0]         mem_wdata;
  logic [BLK_W-1:0]         mem_rdata;
  logic                     mem_ready;

  modport slave (
    input  cpu_ren, cpu_wen, cpu_addr, cpu_wdata, cpu_be,
    output cpu_rdata, cpu_stall,
    output sram_ren, sram_wen, sram_memWen, sram_bytesAccess, sram_blockAddr, sram_dataIn,
    input  sram_hit, sram_dirtyBit, sram_victimTag, sram_dataOut,
    output mem_ren, mem_wen, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport master (
    output cpu_ren, cpu_wen, cpu_addr, cpu_wdata, cpu_be,
    input  cpu_rdata, cpu_stall,
    input  sram_ren, sram_wen, sram_memWen, sram_bytesAccess, sram_blockAddr, sram_dataIn,
    output sram_hit, sram_dirtyBit, sram_victimTag, sram_dataOut,
    input  mem_ren, mem_wen, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/dcache_ctrl.sv
// ---------------------------------------------------------------------------
// dcache_ctrl
//   Write-back, write-allocate controller for a direct-mapped L1 data array.
//   Hits (load or store) complete in the request cycle with no stall. A miss
//   stalls the CPU, writes back a dirty victim, refills the block from main
//   memory, fills the array for one cycle, then lets the held request replay
//   as a hit (a store merges its bytes on that replay cycle).
//   Ports:
//     clk       : clock
//     rst       : asynchronous active-low reset
//     cache_bus : cpu_*/sram_*/mem_* buses (dcache_ctrl_if.slave)
// ---------------------------------------------------------------------------
module dcache_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int BLOCK_BYTES = 16,
  parameter int SETS        = 64
) (
  input  logic           clk,
  input  logic           rst,
  dcache_ctrl_if.slave   cache_bus
);
  localparam int OFF_W   = $clog2(BLOCK_BYTES);
  localparam int IDX_W   = $clog2(SETS);
  localparam int TAG_W   = ADDR_W - OFF_W - IDX_W;
  localparam int BLK_W   = 8 * BLOCK_BYTES;
  localparam int WORDS   = BLOCK_BYTES / 4;
  localparam int BADDR_W = TAG_W + IDX_W;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WRITEBACK = 2'd1;
  localparam logic [1:0] S_REFILL    = 2'd2;
  localparam logic [1:0] S_FILL      = 2'd3;

  logic [1:0]         state_q,      state_d;
  logic [TAG_W-1:0]   vic_tag_q,    vic_tag_d;
  logic [BLK_W-1:0]   vic_data_q,   vic_data_d;
  logic [BADDR_W-1:0] miss_baddr_q, miss_baddr_d;
  logic [OFF_W-1:0]   miss_word_q,  miss_word_d;
  logic [BLK_W-1:0]   fill_q,       fill_d;
  logic [31:0]        rdata_q,      rdata_d;

  logic               req;
  logic [OFF_W-1:0]   word_idx;
  logic [31:0]        hit_word;
  logic [BLOCK_BYTES-1:0] be_blk;

  assign req      = cache_bus.cpu_ren | cache_bus.cpu_wen;
  assign word_idx = cache_bus.cpu_addr[OFF_W-1:0] >> 2;
  assign hit_word = cache_bus.sram_dataOut[32*int'(word_idx) +: 32];
  // Byte enables of the addressed word, placed at that word's lane in the block.
  assign be_blk   = BLOCK_BYTES'(cache_bus.cpu_be) << {word_idx, 2'b00};

  always_comb begin
    // NOTE: every output and next-state value gets a default first, so no path
    // through the case below can leave one unassigned and infer a latch.
    state_d      = state_q;
    vic_tag_d    = vic_tag_q;
    vic_data_d   = vic_data_q;
    miss_baddr_d = miss_baddr_q;
    miss_word_d  = miss_word_q;
    fill_d       = fill_q;
    rdata_d      = rdata_q;

    cache_bus.cpu_rdata        = rdata_q;
    cache_bus.cpu_stall        = 1'b1;
    cache_bus.sram_ren         = 1'b0;
    cache_bus.sram_wen         = 1'b0;
    cache_bus.sram_memWen      = 1'b0;
    cache_bus.sram_bytesAccess = '0;
    cache_bus.sram_blockAddr   = '0;
    cache_bus.sram_dataIn      = '0;
    cache_bus.mem_ren          = 1'b0;
    cache_bus.mem_wen          = 1'b0;
    cache_bus.mem_addr         = '0;
    cache_bus.mem_wdata        = '0;

    case (state_q)
      S_IDLE: begin
        cache_bus.cpu_stall = 1'b0;
        cache_bus.cpu_rdata = '0;
        // Gating with rst keeps the pass-through strobes quiet while reset is held.
        if (rst && req) begin
          cache_bus.sram_ren         = cache_bus.cpu_ren;
          cache_bus.sram_wen         = cache_bus.cpu_wen;
          cache_bus.sram_blockAddr   = cache_bus.cpu_addr[ADDR_W-1:OFF_W];
          cache_bus.sram_dataIn      = {WORDS{cache_bus.cpu_wdata}};
          cache_bus.sram_bytesAccess = be_blk;
          if (cache_bus.cpu_ren) cache_bus.cpu_rdata = hit_word;
          if (!cache_bus.sram_hit) begin
            cache_bus.cpu_stall = 1'b1;
            vic_tag_d    = cache_bus.sram_victimTag;
            vic_data_d   = cache_bus.sram_dataOut;
            miss_baddr_d = cache_bus.cpu_addr[ADDR_W-1:OFF_W];
            miss_word_d  = word_idx;
            state_d      = cache_bus.sram_dirtyBit ? S_WRITEBACK : S_REFILL;
          end
        end
      end

      S_WRITEBACK: begin
        cache_bus.mem_wen   = 1'b1;
        // Victim shares the set index of the missing block.
        cache_bus.mem_addr  = {vic_tag_q, miss_baddr_q[IDX_W-1:0], {OFF_W{1'b0}}};
        cache_bus.mem_wdata = vic_data_q;
        if (cache_bus.mem_ready) state_d = S_REFILL;
      end

      S_REFILL: begin
        cache_bus.mem_ren  = 1'b1;
        cache_bus.mem_addr = {miss_baddr_q, {OFF_W{1'b0}}};
        if (cache_bus.mem_ready) begin
          fill_d  = cache_bus.mem_rdata;
          // Present the requested word early on the registered stall-time output.
          rdata_d = cache_bus.mem_rdata[32*int'(miss_word_q) +: 32];
          state_d = S_FILL;
        end
      end

      default: begin // S_FILL
        cache_bus.sram_memWen      = 1'b1;
        cache_bus.sram_blockAddr   = miss_baddr_q;
        cache_bus.sram_dataIn      = fill_q;
        cache_bus.sram_bytesAccess = '1;
        state_d                    = S_IDLE;
      end
    endcase
  end

  // NOTE: the victim and fill buffers are plain flops, not an array, so they are
  // cleared by reset like any other state and a reset leaves no stale block behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      vic_tag_q    <= '0;
      vic_data_q   <= '0;
      miss_baddr_q <= '0;
      miss_word_q  <= '0;
      fill_q       <= '0;
      rdata_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q      <= state_d;
      vic_tag_q    <= vic_tag_d;
      vic_data_q   <= vic_data_d;
      miss_baddr_q <= miss_baddr_d;
      miss_word_q  <= miss_word_d;
      fill_q       <= fill_d;
      rdata_q      <= rdata_d;
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dcache_ctrl
//   Bench for dcache_ctrl: a direct-mapped array model and a delayed main
//   memory surround the controller; a flat word-addressed golden memory and a
//   tag directory predict load data, writeback contents, and stall length.
// ---------------------------------------------------------------------------
module tb_dcache_ctrl;
  localparam int SETS = 64;

  logic clk;
  logic rst;

  dcache_ctrl_if #(.ADDR_W(32), .BLOCK_BYTES(16), .SETS(SETS)) bus ();

  dcache_ctrl #(.ADDR_W(32), .BLOCK_BYTES(16), .SETS(SETS)) dut (
    .clk       (clk),
    .rst       (rst),
    .cache_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- golden architectural memory (word granular) ----------
  logic [31:0]  gold [int unsigned];
  logic [127:0] bmem [int unsigned];   // backing store seen by the memory port

  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    return gold.exists(a) ? gold[a] : 32'h0;
  endfunction

  function automatic logic [127:0] gold_blk(input logic [31:0] ba);
    logic [127:0] b;
    for (int i = 0; i < 4; i++) b[32*i +: 32] = gold_rd(ba + 32'(4*i));
    return b;
  endfunction

  function automatic logic [127:0] mem_blk(input logic [31:0] ba);
    return bmem.exists(ba) ? bmem[ba] : 128'h0;
  endfunction

  // ---------------- data array model (combinational lookup) -------------
  bit [21:0]    arr_tag   [SETS];
  bit           arr_valid [SETS];
  bit           arr_dirty [SETS];
  bit [127:0]   arr_data  [SETS];
  int           a_idx;
  logic [21:0]  a_tag;

  always_comb begin
    a_idx              = int'(bus.sram_blockAddr[5:0]);
    a_tag              = bus.sram_blockAddr[27:6];
    bus.sram_hit       = arr_valid[a_idx] && (arr_tag[a_idx] == a_tag);
    bus.sram_dirtyBit  = arr_dirty[a_idx];
    bus.sram_victimTag = arr_tag[a_idx];
    bus.sram_dataOut   = arr_data[a_idx];
  end

  always @(posedge clk) begin
    if (bus.sram_memWen) begin
      arr_data[a_idx]  <= bus.sram_dataIn;
      arr_tag[a_idx]   <= a_tag;
      arr_valid[a_idx] <= 1'b1;
      arr_dirty[a_idx] <= 1'b0;
    end else if (bus.sram_wen && bus.sram_hit) begin
      for (int b = 0; b < 16; b++)
        if (bus.sram_bytesAccess[b]) arr_data[a_idx][8*b +: 8] <= bus.sram_dataIn[8*b +: 8];
      arr_dirty[a_idx] <= 1'b1;
    end
  end

  // ---------------- memory responder -------------------------------------
  bit           resp_rdy, spur_rdy;
  int           dly_wb, dly_rf, cnt;
  int           wb_cnt = 0, rf_cnt = 0, fill_cnt = 0, wb_before_rf = 0;
  bit           exp_wb;
  logic [31:0]  exp_wb_addr, exp_rf_addr;
  logic [127:0] exp_wb_data;

  assign bus.mem_ready = resp_rdy | spur_rdy;

  always begin
    @(negedge clk);
    #1;
    resp_rdy = 1'b0;
    if (!rst) begin
      cnt = 0;
      bus.mem_rdata = '0;
    end else if (bus.mem_wen) begin
      check("wb_req", bus.mem_wen, exp_wb);
      check("wb_addr", bus.mem_addr, exp_wb_addr);
      check("wb_data", bus.mem_wdata, exp_wb_data);
      if (cnt == dly_wb) begin
        bmem[bus.mem_addr] = bus.mem_wdata;
        wb_cnt++;
        resp_rdy = 1'b1;
        cnt = 0;
      end else cnt++;
    end else if (bus.mem_ren) begin
      check("rf_addr", bus.mem_addr, exp_rf_addr);
      check("wb_order", wb_cnt, wb_before_rf);
      if (cnt == dly_rf) begin
        bus.mem_rdata = mem_blk(bus.mem_addr);
        rf_cnt++;
        resp_rdy = 1'b1;
        cnt = 0;
      end else cnt++;
    end
  end

  // ---------------- per-cycle protocol monitor ---------------------------
  always begin
    @(negedge clk);
    #2;
    check("sram_excl", ($countones({bus.sram_ren, bus.sram_wen, bus.sram_memWen}) <= 1), 1);
    check("mem_excl", (bus.mem_ren && bus.mem_wen), 0);
    if (bus.mem_ren || bus.mem_wen || bus.sram_memWen) check("stall_busy", bus.cpu_stall, 1);
    if (bus.sram_memWen) fill_cnt++;
  end

  // ---------------- reference directory ----------------------------------
  bit [21:0] ref_tag   [SETS];
  bit        ref_valid [SETS];
  bit        ref_dirty [SETS];

  task automatic drive(input bit ren, input bit wen, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    bus.cpu_ren = ren; bus.cpu_wen = wen; bus.cpu_addr = a;
    bus.cpu_wdata = wd; bus.cpu_be = be;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, {bus.cpu_stall, bus.sram_ren, bus.sram_wen, bus.sram_memWen,
                          bus.mem_ren, bus.mem_wen}, 0);
    check({tag, "_rdata"}, bus.cpu_rdata, 0);
    check({tag, "_maddr"}, bus.mem_addr, 0);
    check({tag, "_mwdata"}, bus.mem_wdata, 0);
    check({tag, "_baddr"}, bus.sram_blockAddr, 0);
    check({tag, "_bytes"}, bus.sram_bytesAccess, 0);
    check({tag, "_din"}, bus.sram_dataIn, 0);
  endtask

  // One CPU access from request to completion, compared against the rules.
  task automatic access(input bit st, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input int dwb, input int drf);
    int idx, stalls, exp_st, f0, w0, r0;
    logic [21:0] tg;
    logic [31:0] w;
    bit hit;
    idx = int'(addr[9:4]);
    tg  = addr[31:10];
    hit = ref_valid[idx] && (ref_tag[idx] == tg);
    exp_wb      = !hit && ref_valid[idx] && ref_dirty[idx];
    exp_wb_addr = {ref_tag[idx], addr[9:4], 4'h0};
    exp_wb_data = gold_blk(exp_wb_addr);
    exp_rf_addr = {addr[31:4], 4'h0};
    dly_wb = dwb; dly_rf = drf;
    f0 = fill_cnt; w0 = wb_cnt; r0 = rf_cnt;
    wb_before_rf = w0 + int'(exp_wb);

    @(negedge clk);
    drive(!st, st, addr, wd, be);
    #3;
    stalls = 0;
    while (bus.cpu_stall && stalls < 200) begin
      stalls++;
      @(negedge clk);
      #3;
    end
    check("stall_timeout", bus.cpu_stall, 0);
    check("strobes", {bus.sram_ren, bus.sram_wen, bus.sram_memWen}, {!st, st, 1'b0});
    check("blk_addr", bus.sram_blockAddr, addr[31:4]);
    if (st) begin
      check("bytes", bus.sram_bytesAccess, 16'(be) << (4 * addr[3:2]));
      check("wdata_rep", bus.sram_dataIn, {4{wd}});
    end else begin
      check("load", bus.cpu_rdata, gold_rd(addr));
    end
    exp_st = hit ? 0 : 1 + (exp_wb ? dwb + 1 : 0) + drf + 1 + 1;
    check("stall_cycles", stalls, exp_st);
    check("fills", fill_cnt - f0, hit ? 0 : 1);
    check("writebacks", wb_cnt - w0, exp_wb);
    check("refills", rf_cnt - r0, !hit);

    if (!hit) begin
      ref_tag[idx] = tg; ref_valid[idx] = 1'b1; ref_dirty[idx] = 1'b0;
    end
    if (st) begin
      ref_dirty[idx] = 1'b1;
      w = gold_rd(addr);
      for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
      gold[addr] = w;
    end

    @(negedge clk);
    drive(0, 0, 32'h0, 32'h0, 4'h0);
    #3;
    check("idle_after", {bus.cpu_stall, bus.sram_ren, bus.sram_wen, bus.sram_memWen}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, r0, k;
    logic [31:0] a;

    // Reset held with a load request present: everything must stay quiet.
    rst = 1'b0;
    drive(1, 0, 32'h40, 32'h0, 4'h0);
    dly_wb = 0; dly_rf = 0;
    repeat (2) @(negedge clk);
    #3;
    check_quiet("reset");
    drive(0, 0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    rst = 1'b1;

    // Clean miss on an empty cache; only word1 of the block is non-zero.
    gold[32'h44] = 32'hDEADBEEF;
    bmem[32'h40] = 128'hDEADBEEF_00000000;
    access(0, 32'h40, 32'h0, 4'h0, 0, 2);
    // Store hit with partial byte enables, then load back the merged word.
    access(1, 32'h44, 32'h11223344, 4'b0011, 0, 0);
    access(0, 32'h44, 32'h0, 4'h0, 0, 0);
    // Conflicting block in the same set evicts the dirty 0x40 block, 5-cycle waits.
    access(0, 32'h440, 32'h0, 4'h0, 5, 5);
    // The evicted data must come back from memory intact.
    access(0, 32'h44, 32'h0, 4'h0, 1, 1);

    // Spurious ready while idle: no fill, no stall, next hit unaffected.
    f0 = fill_cnt;
    @(negedge clk);
    spur_rdy = 1'b1;
    #3;
    check("spur_stall", {bus.cpu_stall, bus.sram_memWen}, 0);
    @(negedge clk);
    spur_rdy = 1'b0;
    #3;
    check("spur_fill", fill_cnt - f0, 0);
    access(0, 32'h44, 32'h0, 4'h0, 0, 0);

    // Reset in the middle of a refill abandons the miss with no array write.
    f0 = fill_cnt; r0 = rf_cnt;
    exp_wb = 1'b0; exp_rf_addr = 32'hA00; wb_before_rf = wb_cnt;
    dly_rf = 8;
    @(negedge clk);
    drive(1, 0, 32'hA00, 32'h0, 4'h0);
    k = 0;
    #3;
    while (!bus.mem_ren && k < 10) begin
      k++;
      @(negedge clk);
      #3;
    end
    check("abort_refill_seen", bus.mem_ren, 1);
    @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_quiet("abort");
    @(negedge clk);
    drive(0, 0, 32'h0, 32'h0, 4'h0);
    #3;
    check_quiet("abort_hold");
    @(negedge clk);
    rst = 1'b1;
    check("abort_fills", fill_cnt - f0, 0);
    check("abort_refills", rf_cnt - r0, 0);
    access(0, 32'hA00, 32'h0, 4'h0, 0, 3);

    // Randomised traffic over a few tags and sets to force conflicts and evictions.
    for (int i = 0; i < 300; i++) begin
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4)
        | (32'($urandom_range(0, 3)) << 2);
      access(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(1, 15)),
             $urandom_range(0, 4), $urandom_range(0, 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
